memory_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. It consumes the Execute→Memory bundle (ex_mem_*) and drives a single-port data memory through a request/ready handshake. It stalls upstream stages while an access is outstanding and registers the Memory→Writeback bundle (mem_wb_*). Loads select memory data or the ALU/shifter value for writeback using ex_mem_selwsource.

---
 rtl/memory_stage.sv | 127 ++++++++++++
 tb/tb_memory_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory-access stage: issues load/store requests to a single-port data memory,
// stalls upstream while an access is outstanding and registers the writeback bundle.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module memory_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_mem_readmem,
  input  logic        ex_mem_writemem,
  input  logic [31:0] ex_mem_regb,
  input  logic        ex_mem_selwsource,
  input  logic [4:0]  ex_mem_regdest,
  input  logic        ex_mem_writereg,
  input  logic [31:0] ex_mem_wbvalue,
  output logic        mem_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] mem_wb_wbvalue,
  output logic [4:0]  mem_wb_regdest,
  output logic        mem_wb_writereg,
  output logic        mem_fault
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;

  logic [1:0] state;
  logic       waiting;
  logic       timeout;

  assign waiting = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // wait_cnt holds the number of stalled wait cycles already spent, so the
  // TIMEOUT-th stalled cycle is the one that gives up.
  assign timeout = waiting && !mem_ready && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                wait_cnt <= '0;
    else if (!waiting || mem_ready || timeout) wait_cnt <= '0;
    else                                       wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mem_fault <= 1'b0;
    else        mem_fault <= timeout;
  end
`else
  assign timeout   = 1'b0;
  assign mem_fault = 1'b0;
`endif

  // Gated by reset so upstream is released the moment reset asserts,
  // even if it is still presenting a memory op.
  assign mem_stall = reset &
                     (((state == IDLE) && (ex_mem_readmem || ex_mem_writemem)) ||
                      (waiting && !mem_ready && !timeout));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_wb_wbvalue  <= '0;
      mem_wb_regdest  <= '0;
      mem_wb_writereg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_mem_writemem) begin
            // Store wins over a simultaneous load request.
            mem_write       <= 1'b1;
            mem_addr        <= ex_mem_wbvalue;
            mem_wdata       <= ex_mem_regb;
            mem_wb_writereg <= 1'b0;
            state           <= WR_WAIT;
          end else if (ex_mem_readmem) begin
            mem_read        <= 1'b1;
            mem_addr        <= ex_mem_wbvalue;
            mem_wb_writereg <= 1'b0;
            state           <= RD_WAIT;
          end else begin
            mem_wb_wbvalue  <= ex_mem_wbvalue;
            mem_wb_regdest  <= ex_mem_regdest;
            mem_wb_writereg <= ex_mem_writereg;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ready) begin
            mem_wb_wbvalue  <= (state == RD_WAIT && ex_mem_selwsource) ? mem_rdata
                                                                        : ex_mem_wbvalue;
            mem_wb_regdest  <= ex_mem_regdest;
            mem_wb_writereg <= ex_mem_writereg;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            state           <= IDLE;
          end else if (timeout) begin
            mem_wb_writereg <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            state           <= IDLE;
          end else begin
            mem_wb_writereg <= 1'b0;
          end
        end
        default: begin
          mem_read        <= 1'b0;
          mem_write       <= 1'b0;
          mem_wb_writereg <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, pass-through, load/store handshakes,
// back-to-back accesses, idle mem_ready and long waits (timeout when enabled).
module tb_memory_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg;
  logic [31:0] ex_mem_regb, ex_mem_wbvalue;
  logic [4:0]  ex_mem_regdest;
  logic        mem_stall, mem_read, mem_write, mem_ready, mem_wb_writereg, mem_fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_wb_wbvalue;
  logic [4:0]  mem_wb_regdest;

  int vectors = 0;
  int miscompares = 0;

  memory_stage dut (
    .clock(clock), .reset(reset),
    .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
    .ex_mem_regb(ex_mem_regb), .ex_mem_selwsource(ex_mem_selwsource),
    .ex_mem_regdest(ex_mem_regdest), .ex_mem_writereg(ex_mem_writereg),
    .ex_mem_wbvalue(ex_mem_wbvalue), .mem_stall(mem_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_wb_wbvalue(mem_wb_wbvalue), .mem_wb_regdest(mem_wb_regdest),
    .mem_wb_writereg(mem_wb_writereg), .mem_fault(mem_fault)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic nop_inputs();
    ex_mem_readmem = 0; ex_mem_writemem = 0; ex_mem_selwsource = 0;
    ex_mem_writereg = 0; ex_mem_regb = 0; ex_mem_wbvalue = 0; ex_mem_regdest = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    nop_inputs();
    tick(); tick();
    vectors++;
    if ({mem_addr, mem_wdata, mem_read, mem_write, mem_stall} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_mem_if: got addr=%h wdata=%h rd=%b wr=%b stall=%b want all 0",
               mem_addr, mem_wdata, mem_read, mem_write, mem_stall);
    end
    vectors++;
    if ({mem_wb_wbvalue, mem_wb_regdest, mem_wb_writereg, mem_fault} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_wb: got wb=%h rd=%0d we=%b fault=%b want all 0",
               mem_wb_wbvalue, mem_wb_regdest, mem_wb_writereg, mem_fault);
    end
    reset = 1;
    tick();
  endtask

  task automatic test_passthrough();
    ex_mem_wbvalue = 32'h1234; ex_mem_regdest = 5; ex_mem_writereg = 1;
    #1;
    vectors++;
    if (mem_stall !== 1'b0) begin
      miscompares++; $display("FAIL pass_stall: got %b want 0", mem_stall);
    end
    tick();
    vectors++;
    if ({mem_wb_wbvalue, mem_wb_regdest, mem_wb_writereg, mem_stall} !== {32'h1234, 5'd5, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL pass_wb: got wb=%h rd=%0d we=%b stall=%b want 1234/5/1/0",
               mem_wb_wbvalue, mem_wb_regdest, mem_wb_writereg, mem_stall);
    end
    nop_inputs();
    tick();
  endtask

  task automatic test_load();
    ex_mem_readmem = 1; ex_mem_wbvalue = 32'h40; ex_mem_selwsource = 1;
    ex_mem_regdest = 7; ex_mem_writereg = 1;
    #1;
    vectors++;
    if (mem_stall !== 1'b1) begin
      miscompares++; $display("FAIL load_issue_stall: got %b want 1", mem_stall);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({mem_read, mem_write, mem_addr, mem_stall, mem_wb_writereg} !== {1'b1, 1'b0, 32'h40, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL load_wait%0d: got rd=%b wr=%b addr=%h stall=%b we=%b want 1/0/40/1/0",
                 i, mem_read, mem_write, mem_addr, mem_stall, mem_wb_writereg);
      end
      tick();
    end
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    vectors++;
    if ({mem_read, mem_stall} !== 2'b10) begin
      miscompares++; $display("FAIL load_ready_cycle: got rd=%b stall=%b want 1/0", mem_read, mem_stall);
    end
    tick();
    vectors++;
    if ({mem_wb_wbvalue, mem_wb_regdest, mem_wb_writereg, mem_read} !== {32'hDEADBEEF, 5'd7, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL load_done: got wb=%h rd=%0d we=%b read=%b want deadbeef/7/1/0",
               mem_wb_wbvalue, mem_wb_regdest, mem_wb_writereg, mem_read);
    end
    nop_inputs();
    tick();
  endtask

  task automatic test_store();
    ex_mem_readmem = 1; ex_mem_writemem = 1; ex_mem_wbvalue = 32'h80;
    ex_mem_regb = 32'hCAFE; ex_mem_selwsource = 1; ex_mem_regdest = 3; ex_mem_writereg = 1;
    tick();
    vectors++;
    if ({mem_write, mem_read, mem_addr, mem_wdata, mem_stall} !== {1'b1, 1'b0, 32'h80, 32'hCAFE, 1'b1}) begin
      miscompares++;
      $display("FAIL store_req: got wr=%b rd=%b addr=%h wdata=%h stall=%b want 1/0/80/cafe/1",
               mem_write, mem_read, mem_addr, mem_wdata, mem_stall);
    end
    mem_ready = 1; mem_rdata = 32'h5555;
    #1;
    vectors++;
    if (mem_stall !== 1'b0) begin
      miscompares++; $display("FAIL store_ready_stall: got %b want 0", mem_stall);
    end
    tick();
    // Stores always write back the ALU value, never memory data.
    vectors++;
    if ({mem_write, mem_wb_wbvalue, mem_wb_regdest, mem_wb_writereg} !== {1'b0, 32'h80, 5'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL store_done: got wr=%b wb=%h rd=%0d we=%b want 0/80/3/1",
               mem_write, mem_wb_wbvalue, mem_wb_regdest, mem_wb_writereg);
    end
    nop_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    ex_mem_readmem = 1; ex_mem_wbvalue = 32'h100; ex_mem_selwsource = 1;
    ex_mem_regdest = 9; ex_mem_writereg = 1;
    tick();
    mem_ready = 1; mem_rdata = 32'h11112222;
    tick();
    nop_inputs();
    ex_mem_writemem = 1; ex_mem_wbvalue = 32'h104; ex_mem_regb = 32'h77;
    #1;
    vectors++;
    if ({mem_read, mem_write, mem_stall, mem_wb_wbvalue, mem_wb_writereg} !== {1'b0, 1'b0, 1'b1, 32'h11112222, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_idle: got rd=%b wr=%b stall=%b wb=%h we=%b want 0/0/1/11112222/1",
               mem_read, mem_write, mem_stall, mem_wb_wbvalue, mem_wb_writereg);
    end
    tick();
    vectors++;
    if ({mem_write, mem_addr, mem_wdata, mem_wb_writereg} !== {1'b1, 32'h104, 32'h77, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_store_req: got wr=%b addr=%h wdata=%h we=%b want 1/104/77/0",
               mem_write, mem_addr, mem_wdata, mem_wb_writereg);
    end
    tick();
    vectors++;
    if ({mem_write, mem_wb_writereg, mem_stall} !== 3'b101) begin
      miscompares++;
      $display("FAIL b2b_bubble: got wr=%b we=%b stall=%b want 1/0/1", mem_write, mem_wb_writereg, mem_stall);
    end
    mem_ready = 1;
    tick();
    vectors++;
    if (mem_write !== 1'b0) begin
      miscompares++; $display("FAIL b2b_store_done: got wr=%b want 0", mem_write);
    end
    nop_inputs();
    tick();
  endtask

  task automatic test_ready_in_idle();
    mem_ready = 1; mem_rdata = 32'hFFFF0000;
    ex_mem_wbvalue = 32'hABC; ex_mem_regdest = 2; ex_mem_writereg = 1; ex_mem_selwsource = 1;
    tick();
    vectors++;
    if ({mem_read, mem_write, mem_stall, mem_wb_wbvalue, mem_wb_regdest} !== {3'b000, 32'hABC, 5'd2}) begin
      miscompares++;
      $display("FAIL idle_ready: got rd=%b wr=%b stall=%b wb=%h rd=%0d want 0/0/0/abc/2",
               mem_read, mem_write, mem_stall, mem_wb_wbvalue, mem_wb_regdest);
    end
    nop_inputs();
    tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    ex_mem_readmem = 1; ex_mem_wbvalue = 32'h200; ex_mem_regdest = 4; ex_mem_writereg = 1;
    tick();
    for (int k = 1; k <= 14; k++) begin
      vectors++;
      if ({mem_stall, mem_fault, mem_read} !== 3'b101) begin
        miscompares++;
        $display("FAIL to_wait%0d: got stall=%b fault=%b rd=%b want 1/0/1", k, mem_stall, mem_fault, mem_read);
      end
      tick();
    end
    vectors++;
    if (mem_stall !== 1'b0) begin
      miscompares++; $display("FAIL to_stall_drop: got %b want 0", mem_stall);
    end
    tick();
    nop_inputs();
    vectors++;
    if ({mem_fault, mem_read, mem_wb_writereg} !== 3'b100) begin
      miscompares++;
      $display("FAIL to_fault: got fault=%b rd=%b we=%b want 1/0/0", mem_fault, mem_read, mem_wb_writereg);
    end
    tick();
    vectors++;
    if (mem_fault !== 1'b0) begin
      miscompares++; $display("FAIL to_pulse: got fault=%b want 0", mem_fault);
    end
  endtask
`else
  task automatic test_long_wait();
    ex_mem_readmem = 1; ex_mem_wbvalue = 32'h200; ex_mem_regdest = 4; ex_mem_writereg = 1;
    tick();
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if ({mem_stall, mem_fault, mem_read, mem_wb_writereg} !== 4'b1010) begin
        miscompares++;
        $display("FAIL long_wait%0d: got stall=%b fault=%b rd=%b we=%b want 1/0/1/0",
                 k, mem_stall, mem_fault, mem_read, mem_wb_writereg);
      end
      tick();
    end
    mem_ready = 1; mem_rdata = 32'h600D;
    ex_mem_selwsource = 1;
    tick();
    vectors++;
    if ({mem_read, mem_wb_wbvalue, mem_wb_writereg} !== {1'b0, 32'h600D, 1'b1}) begin
      miscompares++;
      $display("FAIL long_done: got rd=%b wb=%h we=%b want 0/600d/1", mem_read, mem_wb_wbvalue, mem_wb_writereg);
    end
    nop_inputs();
    tick();
  endtask
`endif

  task automatic test_reset_mid_wait();
    ex_mem_readmem = 1; ex_mem_wbvalue = 32'h300; ex_mem_writereg = 1; ex_mem_regdest = 6;
    tick();
    tick();
    reset = 0;
    #1;
    vectors++;
    if ({mem_read, mem_stall, mem_addr, mem_wb_wbvalue, mem_wb_regdest, mem_wb_writereg} !== 72'd0) begin
      miscompares++;
      $display("FAIL rst_mid: got rd=%b stall=%b addr=%h wb=%h rd=%0d we=%b want all 0",
               mem_read, mem_stall, mem_addr, mem_wb_wbvalue, mem_wb_regdest, mem_wb_writereg);
    end
    nop_inputs();
    mem_ready = 1; mem_rdata = 32'hBAD;
    tick();
    reset = 1;
    tick();
    vectors++;
    if ({mem_read, mem_stall, mem_wb_writereg, mem_wb_wbvalue} !== 35'd0) begin
      miscompares++;
      $display("FAIL rst_release: got rd=%b stall=%b we=%b wb=%h want 0/0/0/0",
               mem_read, mem_stall, mem_wb_writereg, mem_wb_wbvalue);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_back_to_back();
    test_ready_in_idle();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
